return_address_stack: RTL

Hardware return-address stack (RAS) that sits beside the program counter and drives its load path. On a call it captures the return address (current PC + 1). On a return it pops that address and presents it to the PC as a one-cycle load request (`pc_load` into the counter's select input, `pc_target` into its load value). The stack is a fixed-depth circular buffer: overflow drops the oldest entry, underflow is flagged, and neither stalls the core.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/ras_mem.sv | 31 +++
 rtl/return_address_stack.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Definitions shared between the program counter and the return-address stack.
// Holds the PC width and the request decode applied to {call, ret}.
package cpu_pkg;

    localparam int PC_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        POP  = 2'b01,
        PUSH = 2'b10,
        SWAP = 2'b11
    } ras_op_t;

    function automatic ras_op_t decode_op(input logic call, input logic ret);
        ras_op_t op;
        unique case ({call, ret})
            2'b10:   op = PUSH;
            2'b01:   op = POP;
            2'b11:   op = SWAP;
            default: op = IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ras_mem.sv
// Return-address storage: one synchronous write port and one asynchronous read port.
// Contents are deliberately left unreset.
module ras_mem #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8,
    parameter int PW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PW-1:0]     waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [PW-1:0]     raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (we && (waddr == PW'(gi))) begin
                    mem[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = mem[raddr];

endmodule

// File: rtl/return_address_stack.sv
// Circular return-address stack feeding the PC load path: pointer, occupancy
// and sticky error flags; storage lives in ras_mem.
module return_address_stack
    import cpu_pkg::*;
#(
    parameter int ADDR_W = PC_W,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       call,
    input  logic                       ret,
    input  logic [ADDR_W-1:0]          pc_in,
    input  logic                       clear_err,
    output logic                       pc_load,
    output logic [ADDR_W-1:0]          pc_target,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ras_op_t           op;
    logic [PW-1:0]     tos;
    logic [PW-1:0]     tos_inc;
    logic [PW-1:0]     tos_dec;
    logic [ADDR_W-1:0] push_val;
    logic [ADDR_W-1:0] top_val;
    logic              mem_we;
    logic [PW-1:0]     mem_waddr;
    logic              ovf_set;
    logic              unf_set;

    assign op       = decode_op(call, ret);
    assign push_val = pc_in + ADDR_W'(1);
    assign tos_inc  = tos + PW'(1);
    assign tos_dec  = tos - PW'(1);

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A push always lands above the top (overwriting the oldest slot when full);
    // a swap with data present replaces the top in place.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = tos;
        if (!reset) begin
            if (op == PUSH) begin
                mem_we    = 1'b1;
                mem_waddr = tos_inc;
            end else if (op == SWAP && !empty) begin
                mem_we    = 1'b1;
                mem_waddr = tos;
            end
        end
    end

    ras_mem #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .PW     (PW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (push_val),
        .raddr (tos),
        .rdata (top_val)
    );

    assign ovf_set = (op == PUSH) && full;
    assign unf_set = (op == POP) && empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tos       <= '0;
            count     <= '0;
            pc_load   <= 1'b0;
            pc_target <= '0;
        end else begin
            pc_load <= 1'b0;
            unique case (op)
                PUSH: begin
                    tos <= tos_inc;
                    if (!full) begin
                        count <= count + CW'(1);
                    end
                end
                POP: begin
                    if (!empty) begin
                        pc_target <= top_val;
                        pc_load   <= 1'b1;
                        tos       <= tos_dec;
                        count     <= count - CW'(1);
                    end
                end
                SWAP: begin
                    // With nothing stacked the call's own return address is handed straight back.
                    pc_load   <= 1'b1;
                    pc_target <= empty ? push_val : top_val;
                end
                default: begin
                end
            endcase
        end
    end

    // Setting an error wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set | (overflow & ~clear_err);
            underflow <= unf_set | (underflow & ~clear_err);
        end
    end

endmodule
